// File: rtl/shift_buffer_pkg.sv
// Shared constants for the packet receive buffer and the downstream decoder:
// frame width, sync mask and the sync field bounds.
package shift_buffer_pkg;

  localparam int WIDTH = 64;

  localparam logic [WIDTH-1:0] SYNC_MASK = 64'h7C00_001F_0000_01FF;

  localparam int SYNC_A_MSB = 62;
  localparam int SYNC_A_LSB = 58;
  localparam int SYNC_B_MSB = 36;
  localparam int SYNC_B_LSB = 32;
  localparam int SYNC_C_MSB = 8;
  localparam int SYNC_C_LSB = 0;

  typedef enum logic {
    ST_HUNT   = 1'b0,
    ST_FROZEN = 1'b1
  } sb_state_e;

  // All three sync fields are ones; the payload bits are ignored.
  function automatic logic sync_match(input logic [WIDTH-1:0] v);
    return (v & SYNC_MASK) == SYNC_MASK;
  endfunction

endpackage

// File: rtl/shift_buffer_if.sv
// Bit-stream / frame bus between the bit slicer, the receive buffer and the
// packet decoder.
interface shift_buffer_if;
  import shift_buffer_pkg::*;

  logic             en;
  logic             din;
  logic             pkt_rst;
  logic [WIDTH-1:0] dout;
  logic             pkt_rec;

  modport master (output en, din, pkt_rst, input dout, pkt_rec);
  modport slave  (input en, din, pkt_rst, output dout, pkt_rec);

endinterface

// File: rtl/shift_buffer.sv
// Serial-to-parallel receive buffer: shifts din in MSB-first while hunting,
// freezes the frame once all sync fields are ones until pkt_rst releases it.
module shift_buffer
  import shift_buffer_pkg::*;
(
  input  logic          clk,
  input  logic          rst,
  shift_buffer_if.slave bus
);

  sb_state_e        state_q, state_d;
  logic [WIDTH-1:0] sreg_q, sreg_d;
  logic [WIDTH-1:0] nxt;
  logic             shift;

  assign nxt   = {sreg_q[WIDTH-2:0], bus.din};
  assign shift = (state_q == ST_HUNT) && bus.en;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_HUNT;
      sreg_q  <= '0;
    end else begin
      state_q <= state_d;
      sreg_q  <= sreg_d;
    end
  end

  // Detection looks at the value being loaded, so the flag rises on the same
  // edge that shifts in the last sync bit.
  always_comb begin
    state_d = state_q;
    sreg_d  = sreg_q;
    if (bus.pkt_rst) begin
      state_d = ST_HUNT;
      sreg_d  = '0;
    end else if (shift) begin
      sreg_d = nxt;
      if (sync_match(nxt)) state_d = ST_FROZEN;
    end
  end

  assign bus.dout    = sreg_q;
  assign bus.pkt_rec = (state_q == ST_FROZEN);

endmodule

// File: tb/tb_shift_buffer.sv
// Directed bench for shift_buffer: reset, frame detection, freeze, release,
// near-miss frame, gapped enable and clear-vs-match collisions.
module tb_shift_buffer;
  import shift_buffer_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_chk = 0;
  int   n_err = 0;

  shift_buffer_if bus ();

  shift_buffer dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;

  // Hand-built frames: F has payload 21'h15555 / 23'h0; BAD clears dout[34].
  localparam logic [WIDTH-1:0] F   = {1'b0, 5'h1F, 21'h15555, 5'h1F, 23'h0, 9'h1FF};
  localparam logic [WIDTH-1:0] BAD = 64'hFC00_001B_0000_01FF;
  localparam logic [70:0]      STREAM = {8'b10101100, 5'h1F, 21'h15555, 5'h1F, 23'h0, 9'h1FF};

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Apply inputs mid-cycle, return just after the next rising edge.
  task automatic drive(input logic r, input logic e, input logic d, input logic pr);
    @(negedge clk);
    rst         = r;
    bus.en      = e;
    bus.din     = d;
    bus.pkt_rst = pr;
    @(posedge clk);
    #1;
  endtask

  task automatic send71(input logic [70:0] v, input int hi, input int lo);
    for (int i = hi; i >= lo; i--) drive(1'b0, 1'b1, v[i], 1'b0);
  endtask

  task automatic send64(input logic [WIDTH-1:0] v, input int hi, input int lo);
    for (int i = hi; i >= lo; i--) drive(1'b0, 1'b1, v[i], 1'b0);
  endtask

  logic [WIDTH-1:0] model;

  initial begin
    bus.en = 1'b1; bus.din = 1'b1; bus.pkt_rst = 1'b0;

    // 1: reset dominates en/din
    for (int i = 0; i < 2; i++) begin
      drive(1'b1, 1'b1, 1'b1, 1'b0);
      chk("rst_dout", bus.dout, '0);
      chk("rst_rec", 64'(bus.pkt_rec), 64'd0);
    end

    // 2: preamble + frame; flag rises on the edge loading the last sync bit
    send71(STREAM, 70, 63);
    chk("s2_pre8", bus.dout, 64'hAC);
    send71(STREAM, 62, 1);
    chk("s2_rec_pre", 64'(bus.pkt_rec), 64'd0);
    send71(STREAM, 0, 0);
    chk("s2_rec", 64'(bus.pkt_rec), 64'd1);
    chk("s2_dout", bus.dout, F);
    chk("s2_syna", 64'(bus.dout[SYNC_A_MSB:SYNC_A_LSB]), 64'h1F);
    chk("s2_synb", 64'(bus.dout[SYNC_B_MSB:SYNC_B_LSB]), 64'h1F);
    chk("s2_sync", 64'(bus.dout[SYNC_C_MSB:SYNC_C_LSB]), 64'h1FF);

    // 3: frozen ignores further bits; pkt_rst releases
    begin
      logic [7:0] extra;
      extra = 8'b01001110;
      for (int i = 7; i >= 0; i--) drive(1'b0, 1'b1, extra[i], 1'b0);
    end
    chk("s3_hold", bus.dout, F);
    chk("s3_rec", 64'(bus.pkt_rec), 64'd1);
    drive(1'b0, 1'b1, 1'b1, 1'b1);
    chk("s3_clr_dout", bus.dout, '0);
    chk("s3_clr_rec", 64'(bus.pkt_rec), 64'd0);

    // 4: one sync bit missing -> no flag, register keeps shifting
    send64(BAD, 63, 0);
    chk("s4_dout", bus.dout, BAD);
    chk("s4_rec", 64'(bus.pkt_rec), 64'd0);
    drive(1'b0, 1'b1, 1'b0, 1'b0);
    chk("s4_shift", bus.dout, 64'hF800_0036_0000_03FE);
    chk("s4_rec2", 64'(bus.pkt_rec), 64'd0);

    // 5: en gapped every other cycle; din toggled on idle cycles
    drive(1'b0, 1'b0, 1'b0, 1'b1);
    model = '0;
    for (int i = 63; i >= 0; i--) begin
      drive(1'b0, 1'b0, ~F[i], 1'b0);
      chk("s5_idle", bus.dout, model);
      model = {model[WIDTH-2:0], F[i]};
      drive(1'b0, 1'b1, F[i], 1'b0);
      chk("s5_shift", bus.dout, model);
      chk("s5_rec", 64'(bus.pkt_rec), (i == 0) ? 64'd1 : 64'd0);
    end
    drive(1'b0, 1'b0, 1'b1, 1'b0);
    chk("s5_frz", bus.dout, F);

    // 6a: pkt_rst on the completing edge wins
    drive(1'b0, 1'b0, 1'b0, 1'b1);
    send64(F, 63, 1);
    chk("s6_pre_rec", 64'(bus.pkt_rec), 64'd0);
    drive(1'b0, 1'b1, F[0], 1'b1);
    chk("s6_coll_rec", 64'(bus.pkt_rec), 64'd0);
    chk("s6_coll_dout", bus.dout, '0);

    // 6b: rst while frozen
    send64(F, 63, 0);
    chk("s6_frz_rec", 64'(bus.pkt_rec), 64'd1);
    drive(1'b1, 1'b1, 1'b1, 1'b0);
    chk("s6_rst_rec", 64'(bus.pkt_rec), 64'd0);
    chk("s6_rst_dout", bus.dout, '0);

    drive(1'b0, 1'b0, 1'b0, 1'b0);
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
